peripheral_bus: RTL

Memory-mapped peripheral slave on the CPU data path. It sits beside the data memory and consumes the same ALU-computed address, Databus2 write data, MemRead and MemWrite. It provides a reloadable 32-bit timer with interrupt, an LED register, a 7-segment digit register and a free-running cycle counter. Its read data is muxed with data-memory read data by the CPU when the address falls in the peripheral window.

---
 rtl/peripheral_bus.sv | 108 ++++++++++
 1 files changed

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral slave: reloadable timer with interrupt, LED and
// 7-segment registers, and a free-running cycle counter.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       Read_data,
    output logic              hit,
    output logic              irq,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi
);

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [2:0]        tcon_q, tcon_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [31:0]       systick_q, systick_d;
    logic [2:0]        offset_s;
    logic              wr_s;
    logic [31:0]       rdata_s;

    assign offset_s = Address[4:2];
    assign hit      = (Address[31:5] == BASE_ADDR[31:5]) && (offset_s <= 3'd5);
    assign wr_s     = MemWrite & hit;

    // Next-state: timer count/reload first, then a software write overrides it
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d      = th_q;
                tcon_d[2] = tcon_q[2] | tcon_q[1];
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end else begin
            tl_d = tl_q;
        end

        // Reload above used the old TH, so a same-edge TH write only affects TH
        case ({wr_s, offset_s})
            4'b1_000: th_d   = Write_data;
            4'b1_001: tl_d   = Write_data;
            4'b1_010: tcon_d = Write_data[2:0];
            4'b1_011: led_d  = Write_data[LED_W-1:0];
            4'b1_100: digi_d = Write_data[DIGI_W-1:0];
            default:  ;
        endcase
    end

    // Register state with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= 32'd0;
            tl_q      <= 32'd0;
            tcon_q    <= 3'd0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= 32'd0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    // Zero-latency read mux, matching data-memory read timing
    always_comb begin
        rdata_s = 32'd0;
        if (MemRead && hit) begin
            case (offset_s)
                3'd0:    rdata_s = th_q;
                3'd1:    rdata_s = tl_q;
                3'd2:    rdata_s = {29'd0, tcon_q};
                3'd3:    rdata_s = {{(32-LED_W){1'b0}}, led_q};
                3'd4:    rdata_s = {{(32-DIGI_W){1'b0}}, digi_q};
                3'd5:    rdata_s = systick_q;
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign Read_data = rdata_s;
    assign irq       = tcon_q[1] & tcon_q[2];
    assign led       = led_q;
    assign digi      = digi_q;

endmodule
